// File: rtl/video_raster_timing.sv
// Raster timing generator: porches, sync, data enable, frame/line strobes, FIFO read and underrun.
// Optional build macro FRAME_CNT_EN adds a 16-bit frame_count output.
module video_raster_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           bg_fifo_empty,
  input  logic           clear_underrun,
  output logic           fifo_rd,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           new_frame,
  output logic           line_start,
  output logic           underrun
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]    frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive bounds, so nothing ever needs to represent H_TOTAL/V_TOTAL itself.
  localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] HS_FIRST   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST    = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] VS_FIRST   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST    = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           new_frame_q, new_frame_d;
  logic           line_start_q, line_start_d;
  logic           underrun_q, underrun_d;

  logic run;
  logic enter;
  logic adv;
  logic x_wrap;
  logic y_wrap;
  logic frame_wrap;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: RUN is left only through reset
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && !bg_fifo_empty) begin
      state_d = S_RUN;
    end
  end

  // Output decode from the counter registers, forced inactive outside RUN
  always_comb begin
    de    = 1'b0;
    hsync = ~HS_POL;
    vsync = ~VS_POL;
    if (run) begin
      de = (x_q <= X_ACT_LAST) && (y_q <= Y_ACT_LAST);
      if (x_q >= HS_FIRST && x_q <= HS_LAST) begin
        hsync = HS_POL;
      end
      if (y_q >= VS_FIRST && y_q <= VS_LAST) begin
        vsync = VS_POL;
      end
    end
  end

  assign run        = (state_q == S_RUN);
  assign enter      = (state_q == S_IDLE) && !bg_fifo_empty;
  assign adv        = run && enable;
  assign x_wrap     = (x_q == X_LAST);
  assign y_wrap     = (y_q == Y_LAST);
  assign frame_wrap = adv && x_wrap && y_wrap;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = y_wrap ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Strobes are registered so they line up with the counter value they announce
  always_comb begin
    new_frame_d  = enter || frame_wrap;
    line_start_d = enter || (adv && x_wrap && (y_d <= Y_ACT_LAST));
    underrun_d   = (fifo_rd && bg_fifo_empty) || (underrun_q && !clear_underrun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      new_frame_q  <= 1'b0;
      line_start_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      new_frame_q  <= new_frame_d;
      line_start_q <= line_start_d;
      underrun_q   <= underrun_d;
    end
  end

  assign fifo_rd    = de && enable;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign new_frame  = new_frame_q;
  assign line_start = line_start_q;
  assign underrun   = underrun_q;

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts frame wraps only; the first frame after RUN entry is frame 0
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_raster_timing.sv
// Bench for video_raster_timing: directed scenarios on a default-geometry instance and
// randomized checking of a small-geometry instance against a linear pixel-count model.
module tb_video_raster_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-geometry instance
  logic       d_rst, d_en, d_empty, d_clr;
  logic       d_rd, d_de, d_hs, d_vs, d_nf, d_ls, d_ur;
  logic [9:0] d_x, d_y;
`ifdef FRAME_CNT_EN
  logic [15:0] d_fc;
`endif

  // Small-geometry instance (15 x 10 total, active-high syncs)
  logic       s_rst, s_en, s_empty, s_clr;
  logic       s_rd, s_de, s_hs, s_vs, s_nf, s_ls, s_ur;
  logic [3:0] s_x, s_y;
`ifdef FRAME_CNT_EN
  logic [15:0] s_fc;
`endif

  video_raster_timing dut_d (
    .clk(clk), .rst(d_rst), .enable(d_en), .bg_fifo_empty(d_empty),
    .clear_underrun(d_clr), .fifo_rd(d_rd), .de(d_de), .hsync(d_hs), .vsync(d_vs),
    .pixel_x(d_x), .pixel_y(d_y), .new_frame(d_nf), .line_start(d_ls), .underrun(d_ur)
`ifdef FRAME_CNT_EN
    , .frame_count(d_fc)
`endif
  );

  video_raster_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .X_W(4), .Y_W(4)
  ) dut_s (
    .clk(clk), .rst(s_rst), .enable(s_en), .bg_fifo_empty(s_empty),
    .clear_underrun(s_clr), .fifo_rd(s_rd), .de(s_de), .hsync(s_hs), .vsync(s_vs),
    .pixel_x(s_x), .pixel_y(s_y), .new_frame(s_nf), .line_start(s_ls), .underrun(s_ur)
`ifdef FRAME_CNT_EN
    , .frame_count(s_fc)
`endif
  );

  logic [26:0] avec_d, avec_s;
  assign avec_d = {d_x, d_y, d_de, d_hs, d_vs, d_rd, d_nf, d_ls, d_ur};
  assign avec_s = {6'd0, s_x, 6'd0, s_y, s_de, s_hs, s_vs, s_rd, s_nf, s_ls, s_ur};

  // Reference model: raster position is a single count of enabled cycles since entry
  typedef struct packed {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hpol, vpol;
  } geo_t;

  typedef struct packed {
    bit          run;
    int          n;
    bit          nf;
    bit          ls;
    bit          ur;
    logic [15:0] fc;
  } mdl_t;

  geo_t gd, gs;
  mdl_t md, ms;

  function automatic int htot(geo_t g);
    return g.ha + g.hfp + g.hsw + g.hbp;
  endfunction

  function automatic int vtot(geo_t g);
    return g.va + g.vfp + g.vsw + g.vbp;
  endfunction

  function automatic int mx(mdl_t m, geo_t g);
    return m.run ? m.n % htot(g) : 0;
  endfunction

  function automatic int my(mdl_t m, geo_t g);
    return m.run ? m.n / htot(g) : 0;
  endfunction

  function automatic bit mde(mdl_t m, geo_t g);
    return m.run && mx(m, g) < g.ha && my(m, g) < g.va;
  endfunction

  function automatic bit mhs(mdl_t m, geo_t g);
    int x;
    x = mx(m, g);
    return (m.run && x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hsw) ? g.hpol : !g.hpol;
  endfunction

  function automatic bit mvs(mdl_t m, geo_t g);
    int y;
    y = my(m, g);
    return (m.run && y >= g.va + g.vfp && y < g.va + g.vfp + g.vsw) ? g.vpol : !g.vpol;
  endfunction

  function automatic mdl_t mstep(mdl_t m, geo_t g, bit rst_v, bit en_v, bit empty_v, bit clr_v);
    mdl_t r;
    int   ft;
    r    = m;
    ft   = htot(g) * vtot(g);
    r.nf = 1'b0;
    r.ls = 1'b0;
    if (mde(m, g) && en_v && empty_v) r.ur = 1'b1;
    else if (clr_v)                   r.ur = 1'b0;
    if (!m.run) begin
      if (!empty_v) begin
        r.run = 1'b1;
        r.n   = 0;
        r.nf  = 1'b1;
        r.ls  = 1'b1;
      end
    end else if (en_v) begin
      r.n = (m.n + 1) % ft;
      if (r.n == 0) begin
        r.nf = 1'b1;
        r.fc = m.fc + 16'd1;
      end
      if (r.n % htot(g) == 0 && r.n / htot(g) < g.va) r.ls = 1'b1;
    end
    if (rst_v) r = '0;
    return r;
  endfunction

  function automatic logic [26:0] evec(mdl_t m, geo_t g, bit en_v);
    logic [9:0] x, y;
    bit         de;
    x  = 10'(mx(m, g));
    y  = 10'(my(m, g));
    de = mde(m, g);
    return {x, y, de, mhs(m, g), mvs(m, g), de & en_v, m.nf, m.ls, m.ur};
  endfunction

  task automatic tick_d(input bit rst_v, input bit en_v, input bit empty_v, input bit clr_v);
    d_rst = rst_v; d_en = en_v; d_empty = empty_v; d_clr = clr_v;
    md = mstep(md, gd, rst_v, en_v, empty_v, clr_v);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_s(input bit rst_v, input bit en_v, input bit empty_v, input bit clr_v);
    s_rst = rst_v; s_en = en_v; s_empty = empty_v; s_clr = clr_v;
    ms = mstep(ms, gs, rst_v, en_v, empty_v, clr_v);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick_d(1, 1, 1, 0);
    checks++;
    if (avec_d !== evec(md, gd, d_en)) begin
      errors++;
      $display("FAIL reset_values: actual=%h required=%h", avec_d, evec(md, gd, d_en));
    end
    for (int i = 0; i < 100; i++) begin
      tick_d(0, 1, 1, 0);
      checks++;
      if ({d_de, d_hs, d_vs, d_x, d_y, d_rd, d_nf} !== {1'b0, 1'b1, 1'b1, 20'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: actual de/hs/vs/x/y/rd/nf=%b%b%b/%0d/%0d/%b%b required 011/0/0/00",
                 i, d_de, d_hs, d_vs, d_x, d_y, d_rd, d_nf);
      end
    end
  endtask

  task automatic test_entry();
    tick_d(0, 1, 0, 0);
    checks++;
    if ({d_de, d_nf, d_ls, d_x, d_y} !== {1'b1, 1'b1, 1'b1, 20'd0}) begin
      errors++;
      $display("FAIL entry: actual de/nf/ls=%b%b%b x=%0d y=%0d required 111 x=0 y=0",
               d_de, d_nf, d_ls, d_x, d_y);
    end
    for (int i = 1; i <= 800; i++) begin
      tick_d(0, 1, 0, 0);
      checks++;
      if (avec_d !== evec(md, gd, d_en)) begin
        errors++;
        $display("FAIL line0 cycle %0d: actual=%h required=%h", i, avec_d, evec(md, gd, d_en));
      end
      if (i == 1) begin
        checks++;
        if ({d_nf, d_ls} !== 2'b00) begin
          errors++;
          $display("FAIL strobe_width: actual nf/ls=%b%b required 00", d_nf, d_ls);
        end
      end
      if (i == 639 || i == 640) begin
        checks++;
        if (d_de !== (i == 639)) begin
          errors++;
          $display("FAIL de_edge x=%0d: actual=%b required=%b", i, d_de, (i == 639));
        end
      end
      if (i >= 655 && i <= 752) begin
        checks++;
        if (d_hs !== !(i >= 656 && i <= 751)) begin
          errors++;
          $display("FAIL hsync_window x=%0d: actual=%b required=%b", i, d_hs, !(i >= 656 && i <= 751));
        end
      end
      if (i == 800) begin
        checks++;
        if ({d_x, d_y, d_ls} !== {10'd0, 10'd1, 1'b1}) begin
          errors++;
          $display("FAIL line_wrap: actual x=%0d y=%0d ls=%b required x=0 y=1 ls=1", d_x, d_y, d_ls);
        end
      end
    end
  endtask

  task automatic test_enable_third();
    bit en;
    bit prev_ls;
    bit prev_nf;
    prev_ls = d_ls;
    prev_nf = d_nf;
    for (int i = 0; i < 2430; i++) begin
      en = (i % 3 == 0);
      tick_d(0, en, 0, 0);
      checks++;
      if (avec_d !== evec(md, gd, d_en)) begin
        errors++;
        $display("FAIL enable_third cycle %0d: actual=%h required=%h", i, avec_d, evec(md, gd, d_en));
      end
      checks++;
      if ((d_ls && prev_ls) || (d_nf && prev_nf) || (!en && d_rd !== 1'b0)) begin
        errors++;
        $display("FAIL enable_third_pulse cycle %0d: actual ls=%b nf=%b rd=%b en=%b required one-clk strobes, rd only when enabled",
                 i, d_ls, d_nf, d_rd, en);
      end
      prev_ls = d_ls;
      prev_nf = d_nf;
    end
  endtask

  task automatic test_underrun();
    int k;
    k = 0;
    while (k < 5000 && !(mx(md, gd) == 10 && my(md, gd) == 5)) begin
      tick_d(0, 1, 0, 0);
      k++;
    end
    checks++;
    if (d_x !== 10'd10 || d_y !== 10'd5 || d_ur !== 1'b0) begin
      errors++;
      $display("FAIL underrun_setup: actual x=%0d y=%0d ur=%b required x=10 y=5 ur=0", d_x, d_y, d_ur);
    end
    tick_d(0, 1, 1, 0);
    checks++;
    if (d_ur !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set: actual=%b required=1", d_ur);
    end
    for (int i = 0; i < 3; i++) begin
      tick_d(0, 1, 0, 0);
      checks++;
      if (d_ur !== 1'b1 || avec_d !== evec(md, gd, d_en)) begin
        errors++;
        $display("FAIL underrun_hold %0d: actual=%h required=%h", i, avec_d, evec(md, gd, d_en));
      end
    end
    tick_d(0, 1, 0, 1);
    checks++;
    if (d_ur !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: actual=%b required=0", d_ur);
    end
    tick_d(0, 1, 1, 1);
    checks++;
    if (d_ur !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set_wins: actual=%b required=1", d_ur);
    end
    tick_d(0, 1, 0, 1);
    checks++;
    if (d_ur !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear2: actual=%b required=0", d_ur);
    end
    k = 0;
    while (k < 1000 && mx(md, gd) != 700) begin
      tick_d(0, 1, 0, 0);
      k++;
    end
    tick_d(0, 1, 1, 0);
    checks++;
    if (d_ur !== 1'b0 || avec_d !== evec(md, gd, d_en)) begin
      errors++;
      $display("FAIL underrun_blanking: actual=%h required=%h", avec_d, evec(md, gd, d_en));
    end
  endtask

  task automatic test_rst_mid();
    int k;
    k = 0;
    while (k < 1000 && mx(md, gd) != 299) begin
      tick_d(0, 1, 0, 0);
      k++;
    end
    tick_d(0, 1, 1, 0);
    checks++;
    if (d_x !== 10'd300 || d_ur !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: actual x=%0d ur=%b required x=300 ur=1", d_x, d_ur);
    end
    tick_d(1, 1, 0, 0);
    checks++;
    if (avec_d !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: actual=%h required=%h", avec_d,
               {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end
`ifdef FRAME_CNT_EN
    checks++;
    if (d_fc !== 16'd0) begin
      errors++;
      $display("FAIL rst_frame_count: actual=%0d required=0", d_fc);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      tick_d(0, 1, 1, 0);
      checks++;
      if (avec_d !== evec(md, gd, d_en)) begin
        errors++;
        $display("FAIL rst_idle %0d: actual=%h required=%h", i, avec_d, evec(md, gd, d_en));
      end
    end
    tick_d(0, 1, 0, 0);
    checks++;
    if ({d_x, d_y, d_de, d_nf, d_ls} !== {20'd0, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reentry: actual x=%0d y=%0d de/nf/ls=%b%b%b required x=0 y=0 111",
               d_x, d_y, d_de, d_nf, d_ls);
    end
    for (int i = 0; i < 20; i++) begin
      tick_d(0, 1, 0, 0);
      checks++;
      if (avec_d !== evec(md, gd, d_en)) begin
        errors++;
        $display("FAIL reentry_run %0d: actual=%h required=%h", i, avec_d, evec(md, gd, d_en));
      end
    end
  endtask

  task automatic test_frame_wrap();
    int nf_cnt;
    nf_cnt = 0;
    tick_s(1, 0, 1, 0);
    tick_s(0, 1, 0, 0);
    for (int i = 1; i <= 150; i++) begin
      tick_s(0, 1, 0, 0);
      if (s_nf) nf_cnt++;
      checks++;
      if (avec_s !== evec(ms, gs, s_en)) begin
        errors++;
        $display("FAIL frame cycle %0d: actual=%h required=%h", i, avec_s, evec(ms, gs, s_en));
      end
      if (i == 104 || i == 105) begin
        checks++;
        if (s_vs !== (i == 105)) begin
          errors++;
          $display("FAIL vsync_edge n=%0d: actual=%b required=%b", i, s_vs, (i == 105));
        end
      end
    end
    checks++;
    if ({s_x, s_y, s_nf, nf_cnt} !== {4'd0, 4'd0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL frame_wrap: actual x=%0d y=%0d nf=%b pulses=%0d required x=0 y=0 nf=1 pulses=1",
               s_x, s_y, s_nf, nf_cnt);
    end
`ifdef FRAME_CNT_EN
    checks++;
    if (s_fc !== 16'd1) begin
      errors++;
      $display("FAIL frame_count: actual=%0d required=1", s_fc);
    end
`endif
  endtask

  task automatic test_random_small();
    for (int i = 0; i < 3000; i++) begin
      tick_s($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6,
             $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      checks++;
      if (avec_s !== evec(ms, gs, s_en)) begin
        errors++;
        $display("FAIL random cycle %0d: actual=%h required=%h", i, avec_s, evec(ms, gs, s_en));
      end
`ifdef FRAME_CNT_EN
      checks++;
      if (s_fc !== ms.fc) begin
        errors++;
        $display("FAIL random_frame_count cycle %0d: actual=%0d required=%0d", i, s_fc, ms.fc);
      end
`endif
    end
  endtask

  initial begin
    d_rst = 1'b1; d_en = 1'b0; d_empty = 1'b1; d_clr = 1'b0;
    s_rst = 1'b1; s_en = 1'b0; s_empty = 1'b1; s_clr = 1'b0;
    md = '0;
    ms = '0;
    gd = '0;
    gs = '0;
    gd.ha = 640; gd.hfp = 16; gd.hsw = 96; gd.hbp = 48;
    gd.va = 480; gd.vfp = 10; gd.vsw = 2;  gd.vbp = 33;
    gd.hpol = 1'b0; gd.vpol = 1'b0;
    gs.ha = 8; gs.hfp = 2; gs.hsw = 3; gs.hbp = 2;
    gs.va = 6; gs.vfp = 1; gs.vsw = 2; gs.vbp = 1;
    gs.hpol = 1'b1; gs.vpol = 1'b1;

    test_reset();
    test_entry();
    test_enable_third();
    test_underrun();
    test_rst_mid();
    test_frame_wrap();
    test_random_small();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_raster_timing.md
# video_raster_timing

Parametrised raster timing generator that succeeds the fixed 640x480 pixel counter in the VPU output path. It produces full horizontal and vertical timing, including porches and sync, and derives from it `pixel_x`/`pixel_y`, `de`, `hsync`/`vsync`, frame and line strobes, a background-FIFO read request and a sticky underrun flag. Output starts only once the background FIFO holds data, and advances on a pixel-clock enable.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch, sync and back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch, sync and back porch, in lines
- `HS_POL`, 0 / `VS_POL`, 0: active level of `hsync` / `vsync`
- `X_W`, 10 / `Y_W`, 10: counter widths; 2^X_W must be ≥ H_TOTAL and 2^Y_W must be ≥ V_TOTAL
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `enable` in 1: pixel-clock enable
- `bg_fifo_empty` in 1: background FIFO empty flag
- `clear_underrun` in 1: clears `underrun`
- `fifo_rd` out 1: pixel read request to the background FIFO
- `de` out 1: data enable, high in the active region
- `hsync` out 1, `vsync` out 1: sync outputs
- `pixel_x` out X_W, `pixel_y` out Y_W: raw horizontal / vertical counters
- `new_frame` out 1, `line_start` out 1: one-clock strobes
- `underrun` out 1: sticky underrun flag
- `frame_count` out 16: frame counter; present only with `FRAME_CNT_EN`

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V_* parameters.
- State machine:
  - IDLE: counters held at (0,0).
  - IDLE→RUN on the first clk with `!bg_fifo_empty`.
  - RUN→IDLE only via `rst`.
- Counter advance (RUN with `enable`=1 only):
  - `pixel_x` increments each enabled cycle; at H_TOTAL-1 it wraps to 0 and `pixel_y` increments.
  - At (H_TOTAL-1, V_TOTAL-1) both counters wrap to (0,0).
- Decodes are combinational from the counter registers and are gated by RUN; in IDLE, `de`=0 and sync outputs are at their inactive level:
  - `de` = x<H_ACTIVE && y<V_ACTIVE.
  - `hsync` = HS_POL when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - `vsync` = VS_POL over the analogous y window, else ~VS_POL.
- `fifo_rd` = `de` & `enable` (combinational).
- `new_frame` (registered):
  - High for exactly one clk, coincident with the first cycle in which the counters read (0,0) after either the IDLE→RUN entry or a frame wrap.
  - Not stretched by `enable`=0.
- `line_start` (registered):
  - High for one clk, coincident with `pixel_x` becoming 0 on a line where the new y < V_ACTIVE.
  - Also high on RUN entry.
- `underrun`:
  - Set on the clk after any cycle with `fifo_rd` && `bg_fifo_empty`.
  - Cleared on the clk after `clear_underrun`.
  - If set and clear occur in the same cycle, set wins.

## Timing
- Every output is defined on the cycle after the `rst` edge; reset values:
  - state IDLE; `pixel_x`=`pixel_y`=0.
  - `de`=`fifo_rd`=0; `hsync`=~HS_POL, `vsync`=~VS_POL.
  - `new_frame`=`line_start`=`underrun`=0; `frame_count`=0.
- Entry latency: `bg_fifo_empty` seen low at clk edge N puts the block in RUN from N+1, with (0,0), `de`=1, `new_frame`=1 and `line_start`=1.
- After entry, `bg_fifo_empty` is ignored for the run state; it only affects `underrun`.
- Counter latency: a cycle with `enable`=1 updates the counters, and therefore all decodes, at the next edge.
- `rst` mid-frame takes priority over everything else: return to IDLE with all reset values, then re-arm on FIFO non-empty.
- One frame = H_TOTAL·V_TOTAL enabled cycles; with defaults, 800·525 = 420000.

## Configuration
- `FRAME_CNT_EN` defined:
  - 16-bit `frame_count` port present.
  - Increments, with 2^16 wrap-around, on each frame wrap, in the same clk as the `new_frame` it produces.
  - Not incremented on IDLE→RUN entry.
- `FRAME_CNT_EN` undefined: port and register are absent; all other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset, `bg_fifo_empty`=1, `enable`=1 for 100 clk → `de`=0, `hsync`=`vsync`=1, `pixel_x`=`pixel_y`=0, `fifo_rd`=0, `new_frame` never asserted.
- `bg_fifo_empty` falls at edge N with `enable`=1 → at N+1, `de`=1, `new_frame`=`line_start`=1 for one clk. Then:
  - `de` falls when x=640.
  - `hsync`=0 for x=656..751.
  - `pixel_y`=1 and `line_start` pulses at enabled cycle 800.
- `enable` high 1-in-3 → counters advance every third clk; `new_frame`/`line_start` remain one-clk pulses; `fifo_rd` is high only on enabled active cycles.
- 420000 enabled cycles → counters return to (0,0), `new_frame` pulses, `vsync`=0 for y=490..491. With `FRAME_CNT_EN`, `frame_count`=1; after 65536 frames it reads 0.
- `bg_fifo_empty`=1 at (10,5) with `enable` → `underrun`=1 next clk and held. Then:
  - `clear_underrun` alone → 0.
  - `clear_underrun` coincident with a new underrun cycle → stays 1.
- `rst` pulse at (300,200) in RUN → next clk IDLE with all reset values. Re-entry needs `bg_fifo_empty`=0 and restarts at (0,0) with `new_frame`.
